stack_unloader: RTL and testbench

STACK_UNLOADER -- requirements
Module: stack_unloader

---
 rtl/stack_unloader.sv | 193 +++++++++++++++++++
 tb/tb_stack_unloader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unloader.sv
// -----------------------------------------------------------------------------
// stack_unloader
//
// Drains an external LIFO stack into an internal buffer, then replays the
// captured entries in original push order on a valid/ready stream.
//
// Flow: IDLE -> (POP -> CAPTURE)* -> EMIT -> DONE -> IDLE
//   * POP asks the stack for one entry; the entry arrives on stk_d_out one
//     cycle later and is written in CAPTURE (two cycles per entry).
//   * Capture stops on stk_empty, or when DEPTH entries are held and the
//     stack still has more (overflow, sticky until the next start).
//   * The buffer is filled top-of-stack first, so EMIT walks it from
//     count-1 down to 0 to recover push order.
//
// Optional feature (macro STACK_UNLOAD_RESTORE_EN):
//   defined   - every EMIT transfer pushes the emitted entry back onto the
//               stack, leaving it as it was before the unload by DONE.
//   undefined - stk_push and stk_d_in are tied to 0; the unload is destructive.
//
// Parameters:
//   WIDTH  bits per stack entry
//   DEPTH  maximum number of entries captured
//
// Ports:
//   CLK        clock, all state on rising edge
//   RST        asynchronous active-low reset
//   start      begin an unload (sampled in IDLE only)
//   stk_empty  stack empty flag
//   stk_d_out  stack read data, valid the cycle after stk_pop
//   stk_pop    pop request to stack
//   stk_push   push request to stack (restore mode only)
//   stk_d_in   push data to stack (restore mode only)
//   out_valid  out_data valid (high throughout EMIT)
//   out_ready  downstream accepts
//   out_data   emitted entry
//   out_last   high with the final emitted entry
//   busy       unloader not idle
//   done       one-cycle completion pulse
//   overflow   sticky: stack held more than DEPTH entries
//   count      number of entries captured
// -----------------------------------------------------------------------------
module stack_unloader #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 256,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             stk_empty,
    input  logic [WIDTH-1:0] stk_d_out,
    output logic             stk_pop,
    output logic             stk_push,
    output logic [WIDTH-1:0] stk_d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CW-1:0]    count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POP     = 3'd1,
        S_CAPTURE = 3'd2,
        S_EMIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic             overflow_reg;
    logic [AW-1:0]    rd_idx_reg;
    logic [AW-1:0]    rd_addr_next;
    logic [AW-1:0]    emit_start_idx;
    logic [WIDTH-1:0] rd_data_reg;
    logic [WIDTH-1:0] buf_mem [DEPTH];

    logic count_full;
    logic count_zero;
    logic xfer;
    logic at_last;

    assign count_full = (count_reg == CW'(DEPTH));
    assign count_zero = (count_reg == '0);
    assign xfer       = (state_reg == S_EMIT) && out_ready;
    assign at_last    = (rd_idx_reg == '0);
    // Last captured slot; the low bits wrap correctly when count == DEPTH.
    assign emit_start_idx = count_reg[AW-1:0] - AW'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_POP;
            end
            S_POP: begin
                if (stk_empty)       state_next = count_zero ? S_DONE : S_EMIT;
                else if (count_full) state_next = S_EMIT;
                else                 state_next = S_CAPTURE;
            end
            S_CAPTURE: state_next = S_POP;
            S_EMIT: begin
                if (xfer && at_last) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stk_pop   = (state_reg == S_POP) && !stk_empty && !count_full;
        out_valid = (state_reg == S_EMIT);
        out_last  = (state_reg == S_EMIT) && at_last;
        out_data  = (state_reg == S_EMIT) ? rd_data_reg : '0;
        busy      = (state_reg != S_IDLE);
        done      = (state_reg == S_DONE);
`ifdef STACK_UNLOAD_RESTORE_EN
        // Pushing back in emit (push) order rebuilds the original stack.
        stk_push  = xfer;
        stk_d_in  = (state_reg == S_EMIT) ? rd_data_reg : '0;
`else
        stk_push  = 1'b0;
        stk_d_in  = '0;
`endif
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;

    // ---------------- capture / emit bookkeeping ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rd_idx_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        count_reg    <= '0;
                        overflow_reg <= 1'b0;
                        rd_idx_reg   <= '0;
                    end
                end
                S_POP: begin
                    rd_idx_reg <= emit_start_idx;
                    if (!stk_empty && count_full) overflow_reg <= 1'b1;
                end
                S_CAPTURE: count_reg <= count_reg + CW'(1);
                S_EMIT: begin
                    if (xfer && !at_last) rd_idx_reg <= rd_idx_reg - AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Read address one cycle ahead so the registered buffer output already
    // holds the entry EMIT will present; stalls re-read the same slot.
    always_comb begin
        rd_addr_next = rd_idx_reg;
        if (state_reg == S_POP) begin
            rd_addr_next = emit_start_idx;
        end else if (xfer && !at_last) begin
            rd_addr_next = rd_idx_reg - AW'(1);
        end
    end

    // ---------------- capture buffer (block RAM, registered read) ----------------
    always_ff @(posedge CLK) begin
        if (state_reg == S_CAPTURE) begin
            buf_mem[count_reg[AW-1:0]] <= stk_d_out;
        end
        rd_data_reg <= buf_mem[rd_addr_next];
    end

endmodule

// File: tb/tb_stack_unloader.sv
module tb_stack_unloader;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [WIDTH-1:0] dat_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          stk_empty = 1'b1;
    dat_t          stk_d_out = '0;
    logic          out_ready = 1'b0;
    logic          stk_pop, stk_push, out_valid, out_last, busy, done, overflow;
    dat_t          stk_d_in, out_data;
    logic [CW-1:0] count;

    stack_unloader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .stk_empty (stk_empty),
        .stk_d_out (stk_d_out),
        .stk_pop   (stk_pop),
        .stk_push  (stk_push),
        .stk_d_in  (stk_d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    int   n_total = 0;
    int   n_bad   = 0;
    dat_t stk_q[$];     // environment stack, back = top
    dat_t exp_q[$];     // entries still expected on the output stream
    dat_t em_log[$];    // entries actually transferred this run
    int   exp_count = 0;
    int   exp_ovf   = 0;
    int   exp_pops  = 0;
    int   n_pops    = 0;
    int   rdy_mode  = 0; // 0: always ready, 1: toggle, 2: random

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Behavioural stack: acts on requests seen at the rising edge.
    logic env_pop, env_push;
    dat_t env_d;
    always begin
        @(posedge CLK);
        env_pop  = stk_pop;
        env_push = stk_push;
        env_d    = stk_d_in;
        #1;
        if (env_pop && stk_q.size() > 0) stk_d_out = stk_q.pop_back();
        if (env_push) stk_q.push_back(env_d);
        stk_empty = (stk_q.size() == 0);
    end

    // Downstream ready pattern.
    always begin
        @(posedge CLK);
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Per-cycle compare against the reference expectations.
    logic prev_stall = 1'b0;
    dat_t prev_data  = '0;
    logic prev_last  = 1'b0;
    always @(negedge CLK) begin
        if (!RST) begin
            prev_stall = 1'b0;
        end else begin
            chk("pop_push_excl", int'(stk_pop && stk_push), 0);
            if (stk_pop) n_pops++;
            if (out_valid) begin
                if (prev_stall) begin
                    chk("hold_data", int'(out_data), int'(prev_data));
                    chk("hold_last", int'(out_last), int'(prev_last));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_emit", 1, 0);
                    end else begin
                        chk("emit_data", int'(out_data), int'(exp_q[0]));
                        chk("emit_last", int'(out_last), int'(exp_q.size() == 1));
                        em_log.push_back(out_data);
                        void'(exp_q.pop_front());
                    end
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end else begin
                prev_stall = 1'b0;
            end
`ifdef STACK_UNLOAD_RESTORE_EN
            chk("push_on_xfer", int'(stk_push), int'(out_valid && out_ready));
            if (stk_push) chk("push_data", int'(stk_d_in), int'(out_data));
`else
            chk("push_const", int'(stk_push), 0);
            chk("d_in_const", int'(stk_d_in), 0);
`endif
            if (done) begin
                chk("done_count", int'(count), exp_count);
                chk("done_ovf", int'(overflow), exp_ovf);
                chk("done_remaining", exp_q.size(), 0);
                chk("done_pops", n_pops, exp_pops);
            end
        end
    end

    // Reference: the last min(len, DEPTH) pushed entries come out in push order.
    task automatic load_and_expect(input dat_t vals[$]);
        int n;
        n = (vals.size() > DEPTH) ? DEPTH : vals.size();
        stk_q     = vals;
        stk_empty = (vals.size() == 0);
        exp_q.delete();
        for (int i = vals.size() - n; i < vals.size(); i++) exp_q.push_back(vals[i]);
        exp_count = n;
        exp_ovf   = (vals.size() > DEPTH) ? 1 : 0;
        exp_pops  = n;
        n_pops    = 0;
        em_log.delete();
    endtask

    task automatic run_unload(input int tmo, output int lat);
        bit ok;
        ok = 1'b0;
        @(negedge CLK);
        start = 1'b1;
        lat = 0;
        while (lat < tmo) begin
            @(negedge CLK);
            start = 1'b0;
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic post_check(input dat_t vals[$]);
        dat_t es[$];
        int   n_keep;
        int   n_cmp;
        @(negedge CLK);
        chk("post_busy", int'(busy), 0);
        chk("post_done", int'(done), 0);
        chk("post_count", int'(count), exp_count);
        chk("post_ovf", int'(overflow), exp_ovf);
`ifdef STACK_UNLOAD_RESTORE_EN
        n_keep = vals.size();
`else
        n_keep = vals.size() - exp_count;
`endif
        for (int i = 0; i < n_keep; i++) es.push_back(vals[i]);
        chk("stack_size", stk_q.size(), es.size());
        n_cmp = (stk_q.size() < es.size()) ? stk_q.size() : es.size();
        for (int i = 0; i < n_cmp; i++) chk("stack_entry", int'(stk_q[i]), int'(es[i]));
        chk("stack_empty_flag", int'(stk_empty), int'(es.size() == 0));
    endtask

    task automatic chk_seq(input string name, input dat_t want[$]);
        chk(name, em_log.size(), want.size());
        for (int i = 0; i < want.size() && i < em_log.size(); i++)
            chk(name, int'(em_log[i]), int'(want[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dat_t v[$];
        dat_t w[$];
        int   lat;
        bit   seen;

        #1 RST = 1'b0;
        #3;
        chk("rst_stk_pop", int'(stk_pop), 0);
        chk("rst_stk_push", int'(stk_push), 0);
        chk("rst_stk_d_in", int'(stk_d_in), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_count", int'(count), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // Pushed 1,2,3 with downstream always ready.
        rdy_mode = 0;
        v = '{2'd1, 2'd2, 2'd3};
        load_and_expect(v);
        run_unload(100, lat);
        chk("t1_pops", n_pops, 3);
        chk("t1_count", int'(count), 3);
        w = '{2'd1, 2'd2, 2'd3};
        chk_seq("t1_order", w);
        post_check(v);
        $display("txn: push 1,2,3 ready=1 -> done after %0d cycles", lat);

        // Empty stack: IDLE -> POP -> DONE.
        v.delete();
        load_and_expect(v);
        run_unload(20, lat);
        chk("t2_latency", lat, 2);
        chk("t2_pops", n_pops, 0);
        chk("t2_emits", em_log.size(), 0);
        chk("t2_count", int'(count), 0);
        post_check(v);
        $display("txn: empty stack -> done after %0d cycles", lat);

        // Toggling ready: stalls must hold data, order 2,0,3.
        rdy_mode = 1;
        v = '{2'd2, 2'd0, 2'd3};
        load_and_expect(v);
        run_unload(100, lat);
        w = '{2'd2, 2'd0, 2'd3};
        chk_seq("t3_order", w);
        post_check(v);
        $display("txn: push 2,0,3 ready toggling -> done after %0d cycles", lat);

        // Six entries into a DEPTH=4 unloader.
        rdy_mode = 0;
        v = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        load_and_expect(v);
        run_unload(100, lat);
        chk("t4_pops", n_pops, 4);
        chk("t4_overflow", int'(overflow), 1);
        w = '{2'd2, 2'd3, 2'd1, 2'd2};
        chk_seq("t4_order", w);
        chk("t4_stk_empty", int'(stk_empty), 0);
        post_check(v);
        $display("txn: push 6 entries DEPTH=4 -> overflow=%0d done after %0d cycles", overflow, lat);

        // Reset during EMIT after the first of three transfers.
        rdy_mode = 0;
        v = '{2'd1, 2'd2, 2'd3};
        load_and_expect(v);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            #1;
            if (em_log.size() >= 1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_reached_emit", int'(seen), 1);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_count", int'(count), 0);
        chk("t5_rst_pop", int'(stk_pop), 0);
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        $display("txn: reset mid-emit after %0d transfer(s)", em_log.size());
        rdy_mode = 2;
        v = '{2'd3, 2'd1};
        load_and_expect(v);
        run_unload(100, lat);
        w = '{2'd3, 2'd1};
        chk_seq("t5_after_rst", w);
        post_check(v);
        $display("txn: push 3,1 after reset -> done after %0d cycles", lat);

        // Randomized runs.
        for (int it = 0; it < 12; it++) begin
            int len;
            len = $urandom_range(0, 7);
            rdy_mode = $urandom_range(0, 2);
            v.delete();
            for (int i = 0; i < len; i++) v.push_back(dat_t'($urandom_range(0, 3)));
            load_and_expect(v);
            run_unload(200, lat);
            post_check(v);
            $display("txn: random len=%0d ready_mode=%0d -> count=%0d overflow=%0d done after %0d cycles",
                     len, rdy_mode, count, overflow, lat);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
